pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Next-generation control unit for the 5-stage pipelined RV32I core.
- Decodes the IF/ID instruction and carries the resulting control word through internal ID/EX, EX/MEM and MEM/WB control registers.
- Contains the hazard unit (load-use stall, branch/jump flush) and the forwarding selects.
- The datapath pipeline registers instantiate alongside it. This block owns only control state, rd/rs tags, and the stall/flush/forward outputs.

Parameters:
- INSTR_WIDTH, 32, instruction width.
- REG_ADDR_WIDTH, 5, register index width.
- BYTE_OP_EN, 1, when 1 decode funct3 to byte load/store (lbu/sb); when 0, ByteOpM_o is tied 0.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- instr_i  in  INSTR_WIDTH  instruction from IF/ID register (decode stage)
- zero_i  in  1  ALU zero flag of instruction in EX
- ImmSrcD_o  out  3  immediate select for decode: 000 I, 001 S, 010 B, 011 J, 100 U
- ALUControlE_o  out  3  EX ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcE_o  out  1  EX operand B: 1 = immediate
- PCSrcE_o  out  1  take branch/jump target this cycle
- PCSrcRegE_o  out  1  target = rs1 + imm (jalr)
- MemWriteM_o  out  1  data memory write in MEM
- ByteOpM_o  out  1  byte-wide memory access in MEM
- ResultSrcW_o  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4
- RegWriteW_o  out  1  register file write enable
- RdW_o  out  REG_ADDR_WIDTH  writeback destination
- StallF_o, StallD_o  out  1  hold PC / IF-ID register
- FlushD_o, FlushE_o  out  1  clear IF-ID / insert bubble into EX
- ForwardAE_o, ForwardBE_o  out  2  EX operand mux: 00 regfile, 01 W result, 10 M ALU result

Behaviour:
- Decode is combinational on instr_i. Supported opcodes:
  - 0110011 R-type
  - 0010011 I-ALU
  - 0000011 load
  - 0100011 store
  - 1100011 beq/bne (funct3 000/001)
  - 1101111 jal
  - 1100111 jalr
  - 0110111 lui (ALU adds imm to x0)
- Any other opcode decodes to a bubble: all write enables, branch and jump at 0.
- ALU op decode:
  - sub is R-type with funct7[5]=1.
  - Branches use sub.
  - funct3 110 → or, 111 → and, 010 → slt, others → add.
- Pipeline registers: D→E, E→M and M→W. Each holds control bits plus rd; E additionally holds rs1, rs2, branch, jump, jalr and funct3[0].
- Latency: a control word reaches its E/M/W output exactly 1/2/3 cycles after decode.
- PCSrcE_o = jumpE | (branchE & (zero_i XOR funct3E[0])). It is combinational in EX.
- Load-use stall: when ResultSrcE==01 and RdE!=0 and RdE equals instr_i rs1 or rs2:
  - StallF_o=StallD_o=1 and FlushE_o=1 in the same cycle.
  - Result is one bubble; the dependent instruction re-decodes next cycle.
- Control hazard: PCSrcE_o=1 → FlushD_o=1 and FlushE_o=1. This kills two younger instructions and gives a 2-cycle penalty.
- Flush and stall together: a load in EX cannot assert PCSrcE, so the two never coincide. FlushE has the same effect in both cases.
- Forwarding for A and B independently:
  - 10 if RegWriteM & RdM!=0 & RdM==rsE.
  - Else 01 if RegWriteW & RdW!=0 & RdW==rsE.
  - Else 00.
  - M has priority over W.
- Rd = x0 never stalls or forwards. The register file writes on the falling edge, so no D-stage forwarding exists.
- A bubble, whether from flush or reset, clears RegWrite, MemWrite, branch and jump. Other fields are don't-care but are reset to 0.
- rst=1 at a clock edge:
  - All pipeline registers clear and all E/M/W outputs are 0 the following cycle.
  - Stall/flush/forward outputs are 0 after reset (computed from cleared state).
- Reset mid-operation discards all in-flight instructions.

Test Plan:
- Reset: assert rst with instr_i=0x004081B3 (add x3,x1,x4) → next cycle RegWriteW_o=0, MemWriteM_o=0, PCSrcE_o=0, all Forward=00.
- Latency: 0x00100293 (addi x5,x0,1) → ALUSrcE_o=1, ALUControlE_o=000 at +1; RegWriteW_o=1, RdW_o=5, ResultSrcW_o=00 at +3.
- Forward priority: 0x00100293 then 0x40528333 (sub x6,x5,x5) → at the sub's EX cycle ForwardAE_o=ForwardBE_o=10, ALUControlE_o=001.
- Load-use: 0x00012083 (lw x1,0(x2)) followed by 0x004081B3 → one cycle with StallF_o=StallD_o=FlushE_o=1. The add then reaches EX with ForwardAE_o=01.
- Branch taken: 0x00000463 (beq x0,x0,8) with zero_i=1 in EX → PCSrcE_o=1, FlushD_o=FlushE_o=1. The two flushed instructions never raise RegWriteW_o. With zero_i=0: no flush.
- x0 destination: lw x0 followed by an instruction reading x0 → no stall, Forward=00.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: decode-stage instruction and EX zero flag in, per-stage control,
// hazard and forwarding selects out.
interface pipelined_control_unit_if #(
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic [INSTR_WIDTH-1:0]    instr_i;
  logic                      zero_i;
  logic [2:0]                ImmSrcD_o;
  logic [2:0]                ALUControlE_o;
  logic                      ALUSrcE_o;
  logic                      PCSrcE_o;
  logic                      PCSrcRegE_o;
  logic                      MemWriteM_o;
  logic                      ByteOpM_o;
  logic [1:0]                ResultSrcW_o;
  logic                      RegWriteW_o;
  logic [REG_ADDR_WIDTH-1:0] RdW_o;
  logic                      StallF_o;
  logic                      StallD_o;
  logic                      FlushD_o;
  logic                      FlushE_o;
  logic [1:0]                ForwardAE_o;
  logic [1:0]                ForwardBE_o;

  modport master (
    output instr_i, zero_i,
    input  ImmSrcD_o, ALUControlE_o, ALUSrcE_o, PCSrcE_o, PCSrcRegE_o, MemWriteM_o,
           ByteOpM_o, ResultSrcW_o, RegWriteW_o, RdW_o, StallF_o, StallD_o, FlushD_o,
           FlushE_o, ForwardAE_o, ForwardBE_o
  );

  modport slave (
    input  instr_i, zero_i,
    output ImmSrcD_o, ALUControlE_o, ALUSrcE_o, PCSrcE_o, PCSrcRegE_o, MemWriteM_o,
           ByteOpM_o, ResultSrcW_o, RegWriteW_o, RdW_o, StallF_o, StallD_o, FlushD_o,
           FlushE_o, ForwardAE_o, ForwardBE_o
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I 5-stage control unit: decode, D->E->M->W control registers, load-use stall,
// branch/jump flush and EX operand forwarding selects.
module pipelined_control_unit #(
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter bit          BYTE_OP_EN     = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_control_unit_if.slave cu
);
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr;

  assign opcode       = cu.instr_i[6:0];
  assign funct3       = cu.instr_i[14:12];
  assign funct7_b5    = cu.instr_i[30];
  assign unused_instr = ^{cu.instr_i[INSTR_WIDTH-1:31], cu.instr_i[29:25]};

  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b110:  return AluOr;
      3'b111:  return AluAnd;
      3'b010:  return AluSlt;
      default: return AluAdd;
    endcase
  endfunction

  // Decode stage
  logic       reg_write_d, mem_write_d, byte_op_d, alu_src_d, branch_d, jump_d, jalr_d;
  logic [1:0] result_src_d;
  logic [2:0] alu_ctrl_d, imm_src_d;
  reg_addr_t  rd_d, rs1_d, rs2_d;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    byte_op_d    = 1'b0;
    alu_src_d    = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    jalr_d       = 1'b0;
    result_src_d = 2'b00;
    alu_ctrl_d   = AluAdd;
    imm_src_d    = 3'b000;
    rd_d         = cu.instr_i[7 +: REG_ADDR_WIDTH];
    rs1_d        = cu.instr_i[15 +: REG_ADDR_WIDTH];
    rs2_d        = cu.instr_i[20 +: REG_ADDR_WIDTH];
    case (opcode)
      OpR: begin
        reg_write_d = 1'b1;
        alu_ctrl_d  = funct7_b5 ? AluSub : alu_from_funct3(funct3);
      end
      OpIAlu: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctrl_d  = alu_from_funct3(funct3);
      end
      OpLoad: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
        byte_op_d    = BYTE_OP_EN && (funct3 == 3'b100);
      end
      OpStore: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = 3'b001;
        byte_op_d   = BYTE_OP_EN && (funct3 == 3'b000);
      end
      OpBr: begin
        // Only beq/bne are implemented; other branch encodings become bubbles.
        if (funct3[2:1] == 2'b00) begin
          branch_d   = 1'b1;
          alu_ctrl_d = AluSub;
          imm_src_d  = 3'b010;
        end
      end
      OpJal: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = 2'b10;
        imm_src_d    = 3'b011;
      end
      OpJalr: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        jalr_d       = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b10;
      end
      OpLui: begin
        // lui computes x0 + imm; its rs1 field is immediate bits, not a source.
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = 3'b100;
        rs1_d       = '0;
      end
      default: ;
    endcase
  end

  // Execute stage
  logic       reg_write_e, mem_write_e, byte_op_e, alu_src_e, branch_e, jump_e, jalr_e;
  logic       funct3_b0_e;
  logic [1:0] result_src_e;
  logic [2:0] alu_ctrl_e;
  reg_addr_t  rd_e, rs1_e, rs2_e;

  // Memory and writeback stages
  logic       reg_write_m, mem_write_m, byte_op_m, reg_write_w;
  logic [1:0] result_src_m, result_src_w;
  reg_addr_t  rd_m, rd_w;

  logic pc_src_e, lw_stall, flush_e;

  assign pc_src_e = jump_e | (branch_e & (cu.zero_i ^ funct3_b0_e));
  assign lw_stall = (result_src_e == 2'b01) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign flush_e  = lw_stall | pc_src_e;

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      byte_op_e    <= 1'b0;
      alu_src_e    <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      jalr_e       <= 1'b0;
      funct3_b0_e  <= 1'b0;
      result_src_e <= 2'b00;
      alu_ctrl_e   <= 3'b000;
      rd_e         <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
    end else begin
      reg_write_e  <= reg_write_d;
      mem_write_e  <= mem_write_d;
      byte_op_e    <= byte_op_d;
      alu_src_e    <= alu_src_d;
      branch_e     <= branch_d;
      jump_e       <= jump_d;
      jalr_e       <= jalr_d;
      funct3_b0_e  <= funct3[0];
      result_src_e <= result_src_d;
      alu_ctrl_e   <= alu_ctrl_d;
      rd_e         <= rd_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      byte_op_m    <= 1'b0;
      result_src_m <= 2'b00;
      rd_m         <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= '0;
    end else begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      byte_op_m    <= byte_op_e;
      result_src_m <= result_src_e;
      rd_m         <= rd_e;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

  function automatic logic [1:0] fwd_sel(input reg_addr_t rs);
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
    if (reg_write_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    cu.ImmSrcD_o     = imm_src_d;
    cu.ALUControlE_o = alu_ctrl_e;
    cu.ALUSrcE_o     = alu_src_e;
    cu.PCSrcE_o      = pc_src_e;
    cu.PCSrcRegE_o   = jalr_e;
    cu.MemWriteM_o   = mem_write_m;
    cu.ByteOpM_o     = BYTE_OP_EN ? byte_op_m : 1'b0;
    cu.ResultSrcW_o  = result_src_w;
    cu.RegWriteW_o   = reg_write_w;
    cu.RdW_o         = rd_w;
    cu.StallF_o      = lw_stall;
    cu.StallD_o      = lw_stall;
    cu.FlushD_o      = pc_src_e;
    cu.FlushE_o      = flush_e;
    cu.ForwardAE_o   = fwd_sel(rs1_e);
    cu.ForwardBE_o   = fwd_sel(rs2_e);
  end
endmodule
